// File: rtl/fp8_pkg.sv
// Shared fp8 (1s/3e/4m, bias 3) types and constants plus the feeder state encoding.
package fp8_pkg;

   typedef logic [7:0] fp8_t;

   localparam fp8_t FP8_ZERO    = 8'h00;
   localparam fp8_t FP8_NEGZERO = 8'h80;
   localparam fp8_t FP8_ONE     = 8'h30;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/fp8_matrix_bank.sv
// NxN fp8 register file: one write port, whole-array parallel read, synchronous clear.
module fp8_matrix_bank
   import fp8_pkg::*;
#(
   parameter int N  = 3,
   parameter int W  = 8,
   localparam int IW = $clog2(N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en_i,
   input  logic [IW-1:0]     wr_row_i,
   input  logic [IW-1:0]     wr_col_i,
   input  logic [W-1:0]      wr_data_i,
   output logic [N*N*W-1:0]  rd_o
);

   logic [N*N*W-1:0] mem_q;
   logic [N*N*W-1:0] mem_d;

   // Indices >= N match no cell, so out-of-range writes fall away naturally.
   always_comb begin
      mem_d = mem_q;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (wr_en_i && wr_row_i == IW'(r) && wr_col_i == IW'(c)) begin
               mem_d[(r*N+c)*W +: W] = wr_data_i;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read view already includes a write committing at this edge, so a start
   // issued alongside a write launches with the updated element.
   assign rd_o = mem_d;

endmodule

// File: rtl/matrix_feeder.sv
// Skewed A/B operand feeder for an NxN fp8 systolic array.
// Build option: MATRIX_FEEDER_NEGZERO_FLUSH_EN stores 0x80 writes as 0x00.
//
// state | meaning
// IDLE  | banks writable, waiting for start
// RUN   | streaming step t = 0..3N-3 (data then zero flush)
// DONE  | one-cycle done pulse, lanes zero
module matrix_feeder
   import fp8_pkg::*;
#(
   parameter int N  = 3,
   parameter int W  = 8,
   localparam int IW = $clog2(N),
   localparam int TW = $clog2(3*N-2)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic            load_sel,
   input  logic [IW-1:0]   load_row,
   input  logic [IW-1:0]   load_col,
   input  logic [W-1:0]    load_data,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [N*W-1:0]  a_row,
   output logic [N*W-1:0]  b_col
);

   localparam logic [TW-1:0] T_LAST = TW'(3*N-3);

   feeder_state_t    state_q;
   logic [TW-1:0]    t_q;
   logic [N*W-1:0]   a_row_q, b_col_q;
   logic             busy_q, done_q, load_ready_q;

   logic             wr_en;
   logic [W-1:0]     wr_data;
   logic [N*N*W-1:0] a_mem, b_mem;
   logic [TW-1:0]    t_sel;
   logic [N*W-1:0]   a_row_d, b_col_d;

   assign wr_en = load_valid && load_ready_q;

`ifdef MATRIX_FEEDER_NEGZERO_FLUSH_EN
   assign wr_data = (load_data == W'(FP8_NEGZERO)) ? W'(FP8_ZERO) : load_data;
`else
   assign wr_data = load_data;
`endif

   fp8_matrix_bank #(.N(N), .W(W)) u_bank_a (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en && !load_sel),
      .wr_row_i  (load_row),
      .wr_col_i  (load_col),
      .wr_data_i (wr_data),
      .rd_o      (a_mem)
   );

   fp8_matrix_bank #(.N(N), .W(W)) u_bank_b (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en && load_sel),
      .wr_row_i  (load_row),
      .wr_col_i  (load_col),
      .wr_data_i (wr_data),
      .rd_o      (b_mem)
   );

   // Lanes for the step about to be presented: step 0 on launch, t+1 while running.
   assign t_sel = (state_q == ST_RUN) ? t_q + 1'b1 : '0;

   always_comb begin
      int ts;
      int d;
      a_row_d = '0;
      b_col_d = '0;
      ts      = int'(t_sel);
      d       = 0;
      for (int i = 0; i < N; i++) begin
         d = ts - i;
         if (d >= 0 && d < N) begin
            a_row_d[W*i +: W] = a_mem[(i*N+d)*W +: W];
            b_col_d[W*i +: W] = b_mem[(d*N+i)*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         t_q          <= '0;
         a_row_q      <= '0;
         b_col_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q      <= ST_RUN;
                  t_q          <= '0;
                  a_row_q      <= a_row_d;
                  b_col_q      <= b_col_d;
                  busy_q       <= 1'b1;
                  load_ready_q <= 1'b0;
               end
            end
            ST_RUN: begin
               if (t_q == T_LAST) begin
                  state_q <= ST_DONE;
                  t_q     <= '0;
                  a_row_q <= '0;
                  b_col_q <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  t_q     <= t_q + 1'b1;
                  a_row_q <= a_row_d;
                  b_col_q <= b_col_d;
               end
            end
            ST_DONE: begin
               state_q      <= ST_IDLE;
               done_q       <= 1'b0;
               load_ready_q <= 1'b1;
            end
            default: begin
               state_q      <= ST_IDLE;
               t_q          <= '0;
               a_row_q      <= '0;
               b_col_q      <= '0;
               busy_q       <= 1'b0;
               done_q       <= 1'b0;
               load_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign a_row      = a_row_q;
   assign b_col      = b_col_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign load_ready = load_ready_q;

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed bench for matrix_feeder (N=3) with a per-step scoreboard of expected lanes.
module tb_matrix_feeder;

   localparam int N = 3;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic           load_valid;
   logic           load_ready;
   logic           load_sel;
   logic [1:0]     load_row;
   logic [1:0]     load_col;
   logic [W-1:0]   load_data;
   logic           start;
   logic           busy;
   logic           done;
   logic [N*W-1:0] a_row;
   logic [N*W-1:0] b_col;

   matrix_feeder #(.N(N), .W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_sel   (load_sel),
      .load_row   (load_row),
      .load_col   (load_col),
      .load_data  (load_data),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .a_row      (a_row),
      .b_col      (b_col)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N*W-1:0] a;
      logic [N*W-1:0] b;
   } step_t;

   int             checks   = 0;
   int             failures = 0;
   logic [7:0]     ma [N][N];
   logic [7:0]     mb [N][N];
   step_t          sb [$];
   logic [N*W-1:0] first_a, first_b, step2_a, step2_b;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] store_val(input logic [7:0] d);
`ifdef MATRIX_FEEDER_NEGZERO_FLUSH_EN
      return (d == 8'h80) ? 8'h00 : d;
`else
      return d;
`endif
   endfunction

   task automatic write_model(input logic sel, input int row, input int col, input logic [7:0] data);
      if (row < N && col < N) begin
         if (sel) mb[row][col] = store_val(data);
         else     ma[row][col] = store_val(data);
      end
   endtask

   task automatic do_write(input logic sel, input int row, input int col, input logic [7:0] data);
      logic [31:0] r, c;
      r = row;
      c = col;
      @(negedge clk);
      load_valid = 1'b1;
      load_sel   = sel;
      load_row   = r[1:0];
      load_col   = c[1:0];
      load_data  = data;
      @(posedge clk);
      #1 load_valid = 1'b0;
      write_model(sel, row, col, data);
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = 8'h00;
            mb[i][j] = 8'h00;
         end
   endtask

   task automatic push_expected();
      step_t s;
      int d;
      for (int t = 0; t <= 3*N-3; t++) begin
         s.a = '0;
         s.b = '0;
         for (int i = 0; i < N; i++) begin
            d = t - i;
            if (d >= 0 && d < N) begin
               s.a[W*i +: W] = ma[i][d];
               s.b[W*i +: W] = mb[d][i];
            end
         end
         sb.push_back(s);
      end
   endtask

   task automatic run(input bit hold_start, input bit wr_during, input bit wr_same);
      step_t s;
      @(negedge clk);
      check("ready_before_start", 64'(load_ready), 64'd1);
      start = 1'b1;
      if (wr_same) begin
         load_valid = 1'b1;
         load_sel   = 1'b1;
         load_row   = 2'd0;
         load_col   = 2'd0;
         load_data  = 8'h11;
         write_model(1'b1, 0, 0, 8'h11);
      end
      push_expected();
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      if (!hold_start) start = 1'b0;
      for (int t = 0; t < 3*N-2; t++) begin
         @(negedge clk);
         s = sb.pop_front();
         check($sformatf("a_row_t%0d", t), 64'(a_row), 64'(s.a));
         check($sformatf("b_col_t%0d", t), 64'(b_col), 64'(s.b));
         check($sformatf("busy_t%0d", t), 64'(busy), 64'd1);
         check($sformatf("done_t%0d", t), 64'(done), 64'd0);
         check($sformatf("ready_t%0d", t), 64'(load_ready), 64'd0);
         if (t == 0) begin first_a = a_row; first_b = b_col; end
         if (t == 2) begin step2_a = a_row; step2_b = b_col; end
         if (wr_during) begin
            load_valid = 1'b1;
            load_sel   = 1'b0;
            load_row   = 2'd1;
            load_col   = 2'd1;
            load_data  = 8'h55;
         end
      end
      @(negedge clk);
      load_valid = 1'b0;
      check("done_pulse", 64'(done), 64'd1);
      check("busy_at_done", 64'(busy), 64'd0);
      check("lanes_at_done", 64'({a_row, b_col}), 64'd0);
      check("ready_at_done", 64'(load_ready), 64'd0);
      @(negedge clk);
      check("done_cleared", 64'(done), 64'd0);
      check("ready_back", 64'(load_ready), 64'd1);
      check("busy_idle", 64'(busy), 64'd0);
      if (hold_start) begin
         start = 1'b0;
         @(negedge clk);
         check("no_rerun_busy", 64'(busy), 64'd0);
         check("no_rerun_done", 64'(done), 64'd0);
      end
   endtask

   initial begin
      logic saw_done;
      reset      = 1'b1;
      load_valid = 1'b0;
      load_sel   = 1'b0;
      load_row   = '0;
      load_col   = '0;
      load_data  = '0;
      start      = 1'b0;
      clear_model();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_a_row", 64'(a_row), 64'd0);
      check("rst_b_col", 64'(b_col), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ready", 64'(load_ready), 64'd1);

      // A = identity, B = all 0x40; one out-of-range write that must vanish.
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            do_write(1'b0, i, j, (i == j) ? 8'h30 : 8'h00);
            do_write(1'b1, i, j, 8'h40);
         end
      do_write(1'b0, 3, 0, 8'h77);
      run(1'b0, 1'b0, 1'b0);
      check("ident_t0_a", 64'(first_a), 64'h000030);
      check("ident_t0_b", 64'(first_b), 64'h000040);
      check("ident_t2_a", 64'(step2_a), 64'h003000);
      check("ident_t2_b", 64'(step2_b), 64'h404040);

      run(1'b1, 1'b0, 1'b0);
      run(1'b0, 1'b1, 1'b0);
      run(1'b0, 1'b0, 1'b0);
      check("bank_a11_kept", 64'(step2_a[15:8]), 64'h30);

      run(1'b0, 1'b0, 1'b1);
      check("same_cycle_wr_b00", 64'(first_b[7:0]), 64'h11);

      // Abort at t=3 with reset.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("abort_busy_t3", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_lanes", 64'({a_row, b_col}), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_ready", 64'(load_ready), 64'd1);
      reset = 1'b0;
      clear_model();
      saw_done = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("abort_no_done", 64'(saw_done), 64'd0);
      run(1'b0, 1'b0, 1'b0);

      do_write(1'b0, 0, 0, 8'h80);
      run(1'b0, 1'b0, 1'b0);
`ifdef MATRIX_FEEDER_NEGZERO_FLUSH_EN
      check("negzero_a00", 64'(first_a[7:0]), 64'h00);
`else
      check("negzero_a00", 64'(first_a[7:0]), 64'h80);
`endif
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/matrix_feeder.md
# matrix_feeder

Upstream staging stage for the NxN systolic array of fp8 MAC cells (1 sign, 3 exponent bias 3, 4 mantissa bits, value 0x00 = zero). Holds operand matrices A and B in register banks and, on `start`, streams them with diagonal skew: A rows into the west edge (`ain` of column-0 cells), B columns into the north edge (`bin` of row-0 cells). Drives 0x00 on every lane outside the valid skew window, so accumulators hold their value. Pulses `done` once the last product has reached cell (N-1,N-1).

## Interface
- `N`, 3, matrix dimension (2..8)
- `W`, 8, element width; fixed fp8 encoding
- `clk` in 1 rising-edge clock
- `reset` in 1 synchronous, active-high
- `load_valid` in 1 write strobe for one matrix element
- `load_ready` out 1 high in IDLE only; write accepted when `load_valid && load_ready`
- `load_sel` in 1 0 = bank A, 1 = bank B
- `load_row` in $clog2(N) row index
- `load_col` in $clog2(N) column index
- `load_data` in W element value
- `start` in 1 begin streaming; honoured only in IDLE
- `busy` out 1 high in RUN
- `done` out 1 one-cycle pulse after final step
- `a_row` out N*W lane i = `a_row[W*i +: W]`, to `ain` of cell (i,0)
- `b_col` out N*W lane j = `b_col[W*j +: W]`, to `bin` of cell (0,j)

## Operation
- States: IDLE, RUN, DONE. IDLE -start-> RUN; RUN -(t == 3N-3)-> DONE; DONE -> IDLE unconditionally.
- Step counter t, width $clog2(3N-2), 0 at RUN entry, +1 per RUN cycle.
- Step t: lane i of `a_row` = A[i][t-i] if 0 ≤ t-i < N, else 0x00; lane j of `b_col` = B[t-j][j] if 0 ≤ t-j < N, else 0x00.
- Nonzero data occupies t = 0..2N-2; t = 2N-1..3N-3 are flush steps of all zeros (array pass-through delay).
- Write with out-of-range `load_row`/`load_col` (index ≥ N) is dropped.
- Banks hold contents across runs; rerunning without reloading replays the same matrices.
- Write and `start` in the same IDLE cycle: write commits, RUN uses updated bank.
- `start` in RUN or DONE ignored; `load_valid` outside IDLE ignored (`load_ready` low).
- `reset`: state IDLE, t = 0, both banks cleared to 0x00, all outputs to reset values; reset mid-RUN aborts with no `done`.

## Timing
- Reset values: `a_row` = 0, `b_col` = 0, `busy` = 0, `done` = 0, `load_ready` = 1.
- All outputs registered; no combinational path input→output.
- `start` sampled high at edge k: step 0 on `a_row`/`b_col` and `busy` = 1 from edge k+1; step t visible after edge k+1+t.
- `busy` high for exactly 3N-2 cycles (7 at N=3); `done` high for the one cycle after, with lanes 0; `load_ready` returns at the edge after `done`.
- Write accepted at edge visible to the next step read.

## Configuration
- `MATRIX_FEEDER_NEGZERO_FLUSH_EN` defined: writes of 0x80 (negative zero) stored as 0x00, so the MAC zero bypass applies.
- Undefined: `load_data` stored verbatim; 0x80 streams as 0x80.

## Structure
- Shared package `fp8_pkg`: `fp8_t` (8-bit), `FP8_ZERO` = 8'h00, `FP8_NEGZERO` = 8'h80, `FP8_ONE` = 8'h30, feeder state enum.
- One sub-module, `fp8_matrix_bank`: NxN register file, one write port, full-array parallel read, sync clear on `reset`; instantiated twice (A, B). Skew muxing and FSM stay in `matrix_feeder`.

## Test plan
- Reset, then idle 5 cycles -> all outputs at reset values, `load_ready` = 1.
- N=3, A = identity (0x30 diagonal), B all 0x40, start -> t=0: a_row {0,0,0x30} (lane2..0), b_col {0,0,0x40}; t=2: a_row {0,0x30,0}, b_col all 0x40; t=5..6 all zero; `done` at 8th cycle after start edge.
- `start` held high through RUN and DONE -> exactly one run, one `done`; second run only after IDLE is reentered.
- `load_valid` during RUN with 0x55 -> `load_ready` 0, bank unchanged on next run.
- `reset` asserted at t=3 -> next cycle outputs 0, `busy` 0, no `done`, banks read back as 0x00 on next run.
- Write 0x80 to A[0][0], run -> 0x00 at t=0 lane 0 with macro defined, 0x80 without.
